// File: rtl/blc_seq_if.sv
// Operand/result handshake bundle for the binary-log converter.
// The master drives operands and result acceptance; the slave returns results.
interface blc_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] operand;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] logv;
  logic        zero;

  modport master (
    output in_valid, operand, out_ready,
    input  in_ready, out_valid, logv, zero
  );

  modport slave (
    input  in_valid, operand, out_ready,
    output in_ready, out_valid, logv, zero
  );
endinterface

// File: rtl/blc_seq.sv
// Sequential Mitchell log2 approximation: shifts the operand left until its
// leading one reaches bit 15, down-counting the integer part k from 15.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SCAN  | shifting sreg left one bit per cycle, k counting down
// DONE  | result presented on logv/zero, waiting for out_ready
module blc_seq (
  input logic      clk,
  input logic      rst,
  blc_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nx;
  logic [15:0] sreg, sreg_nx;
  logic [3:0]  k, k_nx;
  logic [19:0] logv_q, logv_nx;
  logic        zero_q, zero_nx;
  logic        out_valid_q, out_valid_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sreg        <= '0;
      k           <= '0;
      logv_q      <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nx;
      sreg        <= sreg_nx;
      k           <= k_nx;
      logv_q      <= logv_nx;
      zero_q      <= zero_nx;
      out_valid_q <= out_valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    k_nx     = k;
    logv_nx  = logv_q;
    zero_nx  = zero_q;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          sreg_nx  = bus.operand;
          k_nx     = 4'd15;
          state_nx = SCAN;
        end
      end
      SCAN: begin
        if (sreg == 16'h0000) begin
          zero_nx  = 1'b1;
          logv_nx  = '0;
          state_nx = DONE;
        end else if (sreg[15]) begin
          // Leading one now sits at bit 15, so the bits below it are the fraction.
          zero_nx  = 1'b0;
          logv_nx  = {k, sreg[14:0]};
          state_nx = DONE;
        end else begin
          sreg_nx = {sreg[14:0], 1'b0};
          k_nx    = k - 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    out_valid_nx = (state_nx == DONE);
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.logv      = logv_q;
  assign bus.zero      = zero_q;

endmodule

// File: doc/blc_seq.md
BLC_SEQ -- requirements
Module: blc_seq

Interface
REQ-001 No parameters; all widths fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand valid.
REQ-005 in_ready  output  1  block can accept an operand.
REQ-006 operand  input  16  unsigned binary operand.
REQ-007 out_valid  output  1  result valid.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 logv  output  20  log result: [19:15] integer part k (0..15), [14:0] fraction; format matches the antilog converter's input operand format.
REQ-010 zero  output  1  operand was 0; logv is meaningless-as-log and is driven to 0.

Function
REQ-011 Mitchell approximation: k = index of leading one of operand; fraction = the k bits below the leading one, left-aligned into 15 bits, zero-filled on the right.
REQ-012 FSM states: IDLE, SCAN, DONE; reset state IDLE.
REQ-013 in_ready = 1 only in IDLE and only while rst = 0; in_ready = 0 in SCAN and DONE.
REQ-014 Accept edge: in_valid && in_ready. On it, load operand into a 16-bit shift register sreg, load k counter with 15, go to SCAN.
REQ-015 SCAN with sreg == 0: set zero = 1, logv = 0, go to DONE.
REQ-016 SCAN with sreg[15] = 1: set logv = {k, sreg[14:0]}, zero = 0, go to DONE.
REQ-017 Otherwise in SCAN: sreg <= sreg << 1, k <= k - 1, stay in SCAN. k never underflows, because nonzero sreg reaches sreg[15] = 1 by k = 0.
REQ-018 Latency:
- accept at edge N;
- out_valid first high after edge N+1+(15-k) for a nonzero operand;
- out_valid first high after edge N+1 for a zero operand;
- range 1..16 edges.
REQ-019 DONE: out_valid = 1; logv and zero held stable until out_valid && out_ready; on that edge, go to IDLE and drop out_valid.
REQ-020 No overlap: at most one operation in flight; in_valid outside IDLE is ignored and never captured.
REQ-021 Operand is sampled only at the accept edge; later changes on operand have no effect.
REQ-022 out_valid is registered, with no combinational path from in_valid or out_ready.
REQ-023 logv and zero hold their last result in IDLE and SCAN; they change only on the SCAN->DONE edge or on reset.

Reset
REQ-024 On any edge with rst = 1:
- state <= IDLE;
- out_valid, zero, logv, sreg and k <= 0;
- any in-flight operation is discarded.
REQ-025 rst has priority over the handshake: in_valid/out_ready during a rst-high edge have no effect.
REQ-026 The first accept is possible on the first edge with rst = 0.

Verification
REQ-027 operand 0x8000 -> logv 0x78000, zero 0, out_valid after edge N+1.
REQ-028 operand 0x00F0 -> logv 0x3F000 (k = 7, frac = 0x7000), out_valid after edge N+9; operand 0xFFFF -> logv 0x7FFFF after N+1.
REQ-029 operand 0x0001 -> logv 0x00000, zero 0, out_valid after edge N+16; operand 0x0000 -> logv 0, zero 1, out_valid after edge N+1.
REQ-030 Backpressure: out_ready held 0 for 5 cycles in DONE with in_valid = 1 and operand toggling:
- logv, zero and out_valid stay constant;
- in_ready stays 0;
- no capture occurs;
- the out_ready pulse returns the FSM to IDLE.
REQ-031 Reset mid-operation: operand 0x0001, rst pulsed at cycle 5 of SCAN:
- out_valid is never asserted;
- logv = 0 after the reset edge;
- in_ready = 1 after release;
- the next operand 0x0400 yields logv 0x50000 after edge N+6.
REQ-032 Random regression of 10k operands with random in_valid/out_ready stalls: every logv/zero matches the Mitchell reference model; exactly one result per accepted operand, in order.
